// File: rtl/mmram_match_ctrl.sv
// mmram_match_ctrl: sequencer for the matching memory of the data-driven pipeline.
// Hashes each incoming operand tag to an MMRAM slot, looks the slot up in a
// local occupancy/tag table and issues exactly one access per packet:
// park (WR_E), fire pair (DEL) or constant bypass (DEL at slot 0).
// Optional feature: define MMRAM_PROBE_EN to enable linear probing on a
// collision (PROBE_DEPTH slots, home slot included).
module mmram_match_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int TAG_W       = 18,
  parameter int PROBE_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              MR_N,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [2:0]        pkt_color,
  input  logic [7:0]        pkt_gen,
  input  logic [6:0]        pkt_dest,
  input  logic              pkt_match,
  output logic              mm_req,
  output logic              mm_wr_e,
  output logic              mm_del,
  output logic [ADDR_W-1:0] mm_addr,
  input  logic              mm_done,
  output logic [ADDR_W:0]   occ_count,
  output logic              full,
  output logic              err_collision
);

  localparam int SLOTS = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W:0] SLOTS_C = {1'b0, {ADDR_W{1'b1}}};

  if (PROBE_DEPTH < 1 || PROBE_DEPTH > 8) begin : g_bad_probe_depth
    $error("mmram_match_ctrl: PROBE_DEPTH must be within 1..8");
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                match_q, match_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic                del_q, del_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [SLOTS:0]      occ_q, occ_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [TAG_W-1:0]    tag_mem [0:SLOTS];
  logic [ADDR_W-1:0]   hash;
  logic                slot_occ;
  logic                slot_hit;
`ifdef MMRAM_PROBE_EN
  logic [3:0]          probe_q, probe_d;
  logic                found_q, found_d;
  logic [ADDR_W-1:0]   empty_addr_q, empty_addr_d;
  logic [ADDR_W-1:0]   next_addr;
`endif

  // Home slot of the presented tag; a zero hash is folded onto the last slot
  // because slot 0 is reserved for constant bypass.
  always_comb begin
    hash = ADDR_W'(pkt_dest[5:0] ^ pkt_gen[5:0] ^ {3'b000, pkt_color});
    if (hash == '0) begin
      hash = SLOTS_C[ADDR_W-1:0];
    end
  end

  // Next-state and output computation for the IDLE/LOOKUP/ISSUE sequencer.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    match_d  = match_q;
    addr_d   = addr_q;
    req_d    = req_q;
    wr_d     = wr_q;
    del_d    = del_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    occ_d    = occ_q;
    count_d  = count_q;
`ifdef MMRAM_PROBE_EN
    probe_d      = probe_q;
    found_d      = found_q;
    empty_addr_d = empty_addr_q;
    next_addr    = (addr_q == SLOTS_C[ADDR_W-1:0]) ? ADDR_W'(1) : addr_q + ADDR_W'(1);
`endif
    slot_occ = occ_q[addr_q];
    slot_hit = slot_occ && (tag_mem[addr_q] == tag_q);

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (pkt_valid && ready_q) begin
          tag_d   = {pkt_color, pkt_gen, pkt_dest};
          match_d = pkt_match;
          addr_d  = hash;
          ready_d = 1'b0;
          state_d = LOOKUP;
`ifdef MMRAM_PROBE_EN
          probe_d = 4'd1;
          found_d = 1'b0;
`endif
        end
      end

      LOOKUP: begin
        if (!match_q) begin
          addr_d  = '0;
          wr_d    = 1'b0;
          del_d   = 1'b1;
          req_d   = 1'b1;
          state_d = ISSUE;
        end else if (slot_hit) begin
          wr_d    = 1'b0;
          del_d   = 1'b1;
          req_d   = 1'b1;
          state_d = ISSUE;
`ifdef MMRAM_PROBE_EN
        end else if (probe_q == 4'(PROBE_DEPTH)) begin
          // The whole chain has been scanned without a tag hit, so it is now
          // safe to park in the first hole seen.
          if (found_q || (!slot_occ && !full)) begin
            addr_d  = found_q ? empty_addr_q : addr_q;
            wr_d    = 1'b1;
            del_d   = 1'b0;
            req_d   = 1'b1;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          if (!slot_occ && !found_q && !full) begin
            found_d      = 1'b1;
            empty_addr_d = addr_q;
          end
          addr_d  = next_addr;
          probe_d = probe_q + 4'd1;
`else
        end else if (!slot_occ && !full) begin
          wr_d    = 1'b1;
          del_d   = 1'b0;
          req_d   = 1'b1;
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
`endif
        end
      end

      ISSUE: begin
        if (mm_done) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          del_d   = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
          if (wr_q) begin
            occ_d[addr_q] = 1'b1;
            count_d       = count_q + (ADDR_W+1)'(1);
          end else if (del_q && (addr_q != '0)) begin
            occ_d[addr_q] = 1'b0;
            count_d       = count_q - (ADDR_W+1)'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered outputs and the occupancy table; reset drops any access.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state_q <= IDLE;
      tag_q   <= '0;
      match_q <= 1'b0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      del_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      occ_q   <= '0;
      count_q <= '0;
`ifdef MMRAM_PROBE_EN
      probe_q      <= '0;
      found_q      <= 1'b0;
      empty_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      match_q <= match_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      del_q   <= del_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      occ_q   <= occ_d;
      count_q <= count_d;
`ifdef MMRAM_PROBE_EN
      probe_q      <= probe_d;
      found_q      <= found_d;
      empty_addr_q <= empty_addr_d;
`endif
    end
  end

  // Stored tags need no reset: an entry is only trusted while its occupancy bit is set.
  always_ff @(posedge CLK) begin
    if ((state_q == ISSUE) && mm_done && wr_q) begin
      tag_mem[addr_q] <= tag_q;
    end
  end

  assign pkt_ready     = ready_q;
  assign mm_req        = req_q;
  assign mm_wr_e       = wr_q;
  assign mm_del        = del_q;
  assign mm_addr       = addr_q;
  assign occ_count     = count_q;
  assign full          = (count_q == SLOTS_C);
  assign err_collision = err_q;

endmodule

// File: tb/tb_mmram_match_ctrl.sv
// tb_mmram_match_ctrl: scoreboard bench for mmram_match_ctrl (default build,
// home-slot only). A table model of slots/tags predicts each packet's access.
module tb_mmram_match_ctrl;

  logic       CLK = 1'b0;
  logic       MR_N = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       pkt_ready;
  logic [2:0] pkt_color = '0;
  logic [7:0] pkt_gen = '0;
  logic [6:0] pkt_dest = '0;
  logic       pkt_match = 1'b0;
  logic       mm_req;
  logic       mm_wr_e;
  logic       mm_del;
  logic [5:0] mm_addr;
  logic       mm_done = 1'b0;
  logic [6:0] occ_count;
  logic       full;
  logic       err_collision;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         is_err;
    bit         wr;
    bit         del;
    logic [5:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        prev_req = 1'b0;
  bit          m_occ [64];
  logic [17:0] m_tag [64];

  mmram_match_ctrl dut (
    .CLK(CLK), .MR_N(MR_N),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_color(pkt_color), .pkt_gen(pkt_gen), .pkt_dest(pkt_dest), .pkt_match(pkt_match),
    .mm_req(mm_req), .mm_wr_e(mm_wr_e), .mm_del(mm_del), .mm_addr(mm_addr),
    .mm_done(mm_done), .occ_count(occ_count), .full(full), .err_collision(err_collision)
  );

  always #5 CLK = ~CLK;

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 1; i < 64; i++) n += m_occ[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [5:0] home_slot(input logic [2:0] c, input logic [7:0] g, input logic [6:0] d);
    int h;
    h = (d % 64) ^ (g % 64) ^ c;
    return (h == 0) ? 6'd63 : 6'(h);
  endfunction

  // Expected access for a packet given the current table contents.
  function automatic exp_t predict(input logic [2:0] c, input logic [7:0] g, input logic [6:0] d, input bit m);
    exp_t e;
    logic [5:0] h;
    e = '{is_err: 1'b0, wr: 1'b0, del: 1'b1, addr: 6'd0};
    if (!m) return e;
    h = home_slot(c, g, d);
    e.addr = h;
    if (m_occ[h] && m_tag[h] == {c, g, d}) begin
      e.del = 1'b1;
    end else if (!m_occ[h] && model_count() < 63) begin
      e.wr  = 1'b1;
      e.del = 1'b0;
    end else begin
      e.is_err = 1'b1;
      e.del    = 1'b0;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_occ[i] = 1'b0;
  endtask

  // Wait for pkt_ready (bounded), return with the bench sitting on a negedge.
  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge CLK);
    while (!pkt_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    ok = pkt_ready;
    if (!ok) checkOutput("ready_timeout", 0, 1);
  endtask

  // Present one packet, check its latency, answer with mm_done and check the count.
  task automatic applyStimulus(input logic [2:0] c, input logic [7:0] g, input logic [6:0] d, input bit m);
    exp_t e;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    e = predict(c, g, d, m);
    sb_q.push_back(e);
    pkt_color = c;
    pkt_gen   = g;
    pkt_dest  = d;
    pkt_match = m;
    pkt_valid = 1'b1;
    @(posedge CLK);
    #1 pkt_valid = 1'b0;
    @(negedge CLK);
    checkOutput("lookup_quiet", int'(mm_req | err_collision), 0);
    @(negedge CLK);
    checkOutput("latency", int'(mm_req | err_collision), 1);
    if (!e.is_err) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      mm_done = 1'b1;
      @(posedge CLK);
      #1 mm_done = 1'b0;
      if (e.wr) begin
        m_occ[e.addr] = 1'b1;
        m_tag[e.addr] = {c, g, d};
      end else if (e.addr != 0) begin
        m_occ[e.addr] = 1'b0;
      end
      @(negedge CLK);
      checkOutput("occ_count", int'(occ_count), model_count());
      checkOutput("full", int'(full), (model_count() == 63) ? 1 : 0);
      checkOutput("req_after_done", int'(mm_req), 0);
    end
  endtask

  // Monitor: every new request or collision pulse retires one scoreboard entry.
  always @(negedge CLK) begin
    if (MR_N) begin
      if ((mm_req && !prev_req) || err_collision) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("is_err", int'(err_collision), int'(mon_e.is_err));
          if (!mon_e.is_err) begin
            checkOutput("wr_e", int'(mm_wr_e), int'(mon_e.wr));
            checkOutput("del", int'(mm_del), int'(mon_e.del));
            checkOutput("addr", int'(mm_addr), int'(mon_e.addr));
          end
        end
      end
    end
    prev_req = mm_req;
  end

  // Hard time limit so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    bit ok;
    int waited;
    model_reset();

    repeat (3) @(negedge CLK);
    checkOutput("rst_req", int'(mm_req), 0);
    checkOutput("rst_ready", int'(pkt_ready), 0);
    checkOutput("rst_count", int'(occ_count), 0);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_err", int'(err_collision), 0);
    MR_N = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_release", int'(pkt_ready), 1);

    applyStimulus(3'd0, 8'd0, 7'd4, 1'b1);
    applyStimulus(3'd0, 8'd0, 7'd4, 1'b1);
    applyStimulus(3'd0, 8'd0, 7'd4, 1'b0);
    applyStimulus(3'd0, 8'd0, 7'd4, 1'b1);
    applyStimulus(3'd1, 8'd1, 7'd4, 1'b1);
    applyStimulus(3'd0, 8'd0, 7'd4, 1'b1);
    applyStimulus(3'd0, 8'd4, 7'd4, 1'b1);
    applyStimulus(3'd0, 8'd4, 7'd4, 1'b1);

    @(negedge CLK);
    mm_done = 1'b1;
    @(negedge CLK);
    mm_done = 1'b0;
    @(negedge CLK);
    checkOutput("idle_done_ignored", int'(occ_count), model_count());

    for (int s = 1; s < 64; s++) applyStimulus(3'd0, 8'd0, 7'(s), 1'b1);
    applyStimulus(3'd0, 8'd0, 7'd64, 1'b1);
    applyStimulus(3'd2, 8'd7, 7'd3, 1'b0);
    applyStimulus(3'd0, 8'd0, 7'd5, 1'b1);

    wait_ready(ok);
    if (ok) begin
      e = predict(3'd1, 8'd2, 7'd3, 1'b0);
      sb_q.push_back(e);
      pkt_color = 3'd1;
      pkt_gen   = 8'd2;
      pkt_dest  = 7'd3;
      pkt_match = 1'b0;
      pkt_valid = 1'b1;
      @(posedge CLK);
      #1 pkt_valid = 1'b0;
      waited = 0;
      while (!mm_req && waited < 10) begin
        @(negedge CLK);
        waited++;
      end
      checkOutput("req_before_reset", int'(mm_req), 1);
      #2 MR_N = 1'b0;
      #1;
      checkOutput("reset_drops_req", int'(mm_req), 0);
      checkOutput("reset_clears_count", int'(occ_count), 0);
      model_reset();
      @(negedge CLK);
      MR_N = 1'b1;
      @(negedge CLK);
      checkOutput("ready_after_reset", int'(pkt_ready), 1);
    end

    for (int i = 0; i < 150; i++) begin
      applyStimulus(3'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                    7'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0));
    end

    repeat (3) @(negedge CLK);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
